// File: rtl/jtdd_shram_arb.sv
// rtl/jtdd_shram_arb.sv - shared 512-byte RAM arbiter between main 6309 CPU and 63701 MCU
module jtdd_shram_arb #(
    parameter int AW  = 9,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic          cpu_cs,
    input  logic          cpu_wrn,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_wait,
    input  logic          mcu_cen,
    input  logic          mcu_cs,
    input  logic          mcu_wrn,
    input  logic [AW-1:0] mcu_addr,
    input  logic [7:0]    mcu_din,
    output logic [7:0]    mcu_dout,
    input  logic          mcu_ban,
    input  logic          mcu_ba,
    output logic          mcu_halt,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_q,
    output logic          tmo_err
);

    typedef enum logic [1:0] {IDLE, HREQ, CPU, REL} state_t;

    localparam logic [7:0] TMO_CNT = 8'(TMO);

    state_t     st;
    logic [7:0] cnt;
    logic       cpu_own;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            cnt      <= 8'd0;
            mcu_halt <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (cpu_cs) begin
                        if (mcu_ban) begin
                            st       <= CPU;
                            mcu_halt <= 1'b0;
                        end else begin
                            st       <= HREQ;
                            mcu_halt <= 1'b1;
                            cnt      <= 8'd0;
                        end
                    end
                end
                HREQ: begin
                    cnt <= cnt + 8'd1;
                    if (!cpu_cs) begin
                        st       <= IDLE;
                        mcu_halt <= 1'b0;
                    end else if (mcu_ba || mcu_ban) begin
                        st       <= CPU;
                        mcu_halt <= !mcu_ban;
                    end else if (cnt == TMO_CNT) begin
                        // MCU never acknowledged: force the grant, keep it halted
                        st      <= CPU;
                        tmo_err <= 1'b1;
                    end
                end
                CPU: begin
                    mcu_halt <= !mcu_ban;
                    if (cpu_cen && !cpu_cs) st <= REL;
                end
                REL: begin
                    if (cpu_cs) begin
                        st       <= CPU;
                        mcu_halt <= !mcu_ban;
                    end else if (mcu_cen) begin
                        st       <= IDLE;
                        mcu_halt <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign cpu_own  = (st == CPU) || (st == REL);
    assign ram_addr = cpu_own ? cpu_addr : mcu_addr;
    assign ram_din  = cpu_own ? cpu_din  : mcu_din;
    assign cpu_wait = cpu_cs && (st != CPU);
    assign cpu_dout = ram_q;
    assign mcu_dout = ram_q;

    // A halted MCU (ba high) must never write; reset drops any strobe in flight
    always_comb begin
        ram_we = 1'b0;
        if (!rst) begin
            if (st == CPU)
                ram_we = cpu_cen && cpu_cs && !cpu_wrn;
            else if (st == IDLE || st == HREQ)
                ram_we = mcu_cen && mcu_cs && !mcu_wrn && !mcu_ba;
        end
    end

endmodule

// File: tb/tb_jtdd_shram_arb.sv
// tb/tb_jtdd_shram_arb.sv - scoreboard bench for jtdd_shram_arb
module tb_jtdd_shram_arb;
    localparam int AW  = 9;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_cen = 1'b0, cpu_cs = 1'b0, cpu_wrn = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0, cpu_dout;
    logic          cpu_wait;
    logic          mcu_cen = 1'b0, mcu_cs = 1'b0, mcu_wrn = 1'b1;
    logic [AW-1:0] mcu_addr = '0;
    logic [7:0]    mcu_din = '0, mcu_dout;
    logic          mcu_ban = 1'b0, mcu_ba = 1'b0, mcu_halt;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din, ram_q = '0;
    logic          ram_we, tmo_err;

    jtdd_shram_arb #(.AW(AW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .cpu_cen(cpu_cen), .cpu_cs(cpu_cs), .cpu_wrn(cpu_wrn), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .mcu_cen(mcu_cen), .mcu_cs(mcu_cs), .mcu_wrn(mcu_wrn), .mcu_addr(mcu_addr),
        .mcu_din(mcu_din), .mcu_dout(mcu_dout), .mcu_ban(mcu_ban), .mcu_ba(mcu_ba),
        .mcu_halt(mcu_halt), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_q(ram_q), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;
    exp_t sbq[$];

    int errors = 0, checks = 0;
    int we_cnt = 0, mcu_we_ba = 0;
    int ba_delay = 0, ba_cnt = 0;
    bit mcu_cen_fixed = 1'b1;
    bit halt_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MCU model: clock enable and a bus-available reply ba_delay clk after halt
    initial forever begin
        @(negedge clk);
        mcu_cen = mcu_cen_fixed ? 1'b1 : ~mcu_cen;
        if (mcu_halt) halt_seen = 1'b1;
        if (mcu_halt && ba_delay != 0) begin
            ba_cnt++;
            if (ba_cnt > ba_delay && !mcu_ba) begin
                mcu_ba  = 1'b1;
                mcu_din = 8'h3C;
            end
        end else begin
            ba_cnt = 0;
            mcu_ba = 1'b0;
        end
    end

    // Monitor: pops an expected byte whenever the CPU samples read data
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (ram_we) we_cnt++;
            if (ram_we && mcu_ba && cpu_wait) mcu_we_ba++;
            if (cpu_cs && cpu_wrn && cpu_cen && !cpu_wait) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %02h expected none", cpu_dout);
                end else begin
                    e = sbq.pop_front();
                    check(e.name, {24'd0, cpu_dout}, {24'd0, e.val});
                end
            end
        end
    end

    task automatic cpu_access(input bit wr, input logic [AW-1:0] a, input logic [7:0] d,
                              output int nwait);
        cpu_cs = 1'b1; cpu_wrn = !wr; cpu_addr = a; cpu_din = d; cpu_cen = 1'b0;
        if (!wr) sbq.push_back('{$sformatf("rd_%03h", a), d});
        nwait = 0;
        do begin
            @(negedge clk);
            nwait++;
        end while (cpu_wait && nwait < 300);
        if (cpu_wait) check("grant_bound", {31'd0, cpu_wait}, 32'd0);
        if (wr) begin
            cpu_cen = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
            cpu_cen = 1'b1;
            @(negedge clk);
        end
        cpu_cs = 1'b0; cpu_cen = 1'b1;
        @(negedge clk);
        cpu_cen = 1'b0;
    endtask

    task automatic wait_halt_low(output int n);
        n = 0;
        while (mcu_halt && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int nw, n, we0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;

        // Reset state: MCU owns the port, strobe gated, wait mirrors cs
        cpu_cs = 1'b1; mcu_cs = 1'b1; mcu_wrn = 1'b0; mcu_addr = 9'h123;
        repeat (3) @(negedge clk);
        check("rst_wait", {31'd0, cpu_wait}, 32'd1);
        check("rst_halt", {31'd0, mcu_halt}, 32'd0);
        check("rst_tmo", {31'd0, tmo_err}, 32'd0);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        check("rst_addr", {23'd0, ram_addr}, 32'h123);
        cpu_cs = 1'b0; mcu_cs = 1'b0; mcu_wrn = 1'b1;
        rst = 1'b0;
        mcu_cen_fixed = 1'b0;
        repeat (3) @(negedge clk);

        // Banned MCU: immediate grant, no halt
        mcu_ban = 1'b1; halt_seen = 1'b0;
        cpu_access(1'b1, 9'h1F0, 8'h5A, nw);
        check("ban_wait_clks", nw, 1);
        cpu_access(1'b0, 9'h1F0, 8'h5A, nw);
        check("ban_no_halt", {31'd0, halt_seen}, 32'd0);
        mcu_ban = 1'b0;
        repeat (4) @(negedge clk);

        // Handshake: ba 6 clk after halt gives an 8 clk stall
        ba_delay = 6;
        mem[9'h010] = 8'h9D;
        cpu_access(1'b0, 9'h010, 8'h9D, nw);
        check("hs_wait_clks", nw, 8);
        check("rel_halt_held", {31'd0, mcu_halt}, 32'd1);
        wait_halt_low(n);
        check("rel_halt_drop", {31'd0, n <= 2}, 32'd1);
        repeat (4) @(negedge clk);

        // Withdrawn request in HREQ: no write, back to idle
        ba_delay = 0; we0 = we_cnt;
        cpu_cs = 1'b1; cpu_wrn = 1'b0; cpu_addr = 9'h0AA; cpu_din = 8'h77;
        repeat (3) @(negedge clk);
        check("hreq_halt", {31'd0, mcu_halt}, 32'd1);
        cpu_cs = 1'b0; cpu_wrn = 1'b1;
        repeat (2) @(negedge clk);
        check("wd_halt", {31'd0, mcu_halt}, 32'd0);
        check("wd_no_we", we_cnt - we0, 0);
        check("wd_tmo", {31'd0, tmo_err}, 32'd0);
        repeat (4) @(negedge clk);

        // Timeout: grant TMO+1 clk after HREQ entry, flag is sticky
        cpu_access(1'b0, 9'h010, 8'h9D, nw);
        check("tmo_wait_clks", nw, TMO + 2);
        check("tmo_err_set", {31'd0, tmo_err}, 32'd1);
        wait_halt_low(n);
        repeat (4) @(negedge clk);
        ba_delay = 6;
        cpu_access(1'b0, 9'h010, 8'h9D, nw);
        check("tmo_2nd_wait", nw, 8);
        check("tmo_err_sticky", {31'd0, tmo_err}, 32'd1);
        wait_halt_low(n);
        repeat (4) @(negedge clk);

        // MCU writes while CPU requests: nothing lands once ba is high
        mcu_cen_fixed = 1'b1; mcu_we_ba = 0;
        mcu_cs = 1'b1; mcu_wrn = 1'b0; mcu_addr = 9'h100; mcu_din = 8'hC3;
        repeat (3) @(negedge clk);
        cpu_access(1'b0, 9'h100, 8'hC3, nw);
        mcu_cs = 1'b0; mcu_wrn = 1'b1;
        check("mcu_we_blocked", mcu_we_ba, 0);
        wait_halt_low(n);
        mcu_cen_fixed = 1'b0;
        repeat (4) @(negedge clk);

        // Async reset during a granted CPU write
        cpu_cs = 1'b1; cpu_wrn = 1'b0; cpu_addr = 9'h1F0; cpu_din = 8'hEE;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_wait && n < 300);
        check("rst_grant", {31'd0, cpu_wait}, 32'd0);
        we0 = we_cnt;
        cpu_cen = 1'b1; rst = 1'b1;
        #1;
        check("rst_halt_async", {31'd0, mcu_halt}, 32'd0);
        check("rst_we_drop", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0; cpu_cs = 1'b0; cpu_cen = 1'b0; cpu_wrn = 1'b1;
        check("rst_tmo_clr", {31'd0, tmo_err}, 32'd0);
        check("rst_no_we", we_cnt - we0, 0);
        repeat (3) @(negedge clk);
        check("rst_idle_halt", {31'd0, mcu_halt}, 32'd0);
        mcu_ban = 1'b1;
        cpu_access(1'b0, 9'h1F0, 8'h5A, nw);
        mcu_ban = 1'b0;
        repeat (4) @(negedge clk);

        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/jtdd_shram_arb.md
# jtdd_shram_arb

Arbiter for the 512-byte RAM shared by the main 6309 CPU and the 63701 MCU. The MCU owns the RAM port by default. A main-CPU access halts the MCU, waits for bus-available, and only then grants the port to the CPU, stalling the CPU meanwhile. A timeout and a ban/bypass path stop the CPU from deadlocking when the MCU is held in reset or misbehaves.

## Interface
Parameters:
- AW, 9, RAM address width
- TMO, 255, clk cycles to wait for mcu_ba before forcing the CPU grant (8-bit counter, 1..255)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cpu_cen  in  1  main CPU clock enable
- cpu_cs  in  1  main CPU selects shared RAM
- cpu_wrn  in  1  main CPU write, active low
- cpu_addr  in  AW  main CPU address
- cpu_din  in  8  main CPU write data
- cpu_dout  out  8  read data to main CPU
- cpu_wait  out  1  stall request to main CPU
- mcu_cen  in  1  MCU clock enable
- mcu_cs  in  1  MCU selects shared RAM
- mcu_wrn  in  1  MCU write, active low
- mcu_addr  in  AW  MCU address
- mcu_din  in  8  MCU write data
- mcu_dout  out  8  read data to MCU
- mcu_ban  in  1  MCU held off the bus (reset/banned); halt handshake bypassed
- mcu_ba  in  1  MCU bus-available acknowledge
- mcu_halt  out  1  halt request to MCU
- ram_addr  out  AW  RAM address
- ram_din  out  8  RAM write data
- ram_we  out  1  RAM write strobe, one clk wide
- ram_q  in  8  RAM read data, 1 clk latency
- tmo_err  out  1  sticky flag: a grant was forced by timeout

## Operation
- States:
  - IDLE: MCU owns the port.
  - HREQ: halt requested, waiting for bus-available.
  - CPU: CPU owns the port.
  - REL: release.
- IDLE → CPU when cpu_cs & mcu_ban. IDLE → HREQ when cpu_cs & !mcu_ban.
- HREQ: mcu_halt=1 and the counter increments every clk.
  - → CPU on mcu_ba or mcu_ban.
  - → CPU on counter==TMO, which also sets tmo_err.
  - → IDLE if cpu_cs drops before the grant; no RAM access takes place.
- CPU: mcu_halt=1 unless mcu_ban. → REL when cpu_cen & !cpu_cs.
- REL: mcu_halt held. → IDLE on the next mcu_cen; mcu_halt drops on that transition. If cpu_cs rises again while in REL → CPU directly.
- Port mux:
  - States CPU and REL drive ram_addr and ram_din from the CPU.
  - IDLE and HREQ drive them from the MCU.
- ram_we in state CPU: cpu_cen & cpu_cs & !cpu_wrn.
- ram_we in IDLE/HREQ: mcu_cen & mcu_cs & !mcu_wrn & !mcu_ba. A halted MCU never writes.
- cpu_wait = cpu_cs & (state != CPU), combinational.
- cpu_dout and mcu_dout both show ram_q. Each is valid only while its owner holds the port.
- The counter clears on every entry to HREQ.
- tmo_err clears only on rst.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - mcu_halt 0, tmo_err 0, ram_we 0.
  - cpu_wait = cpu_cs; ram_addr and ram_din follow the MCU inputs.
- Grant latency from cpu_cs with mcu_ban=1: state CPU one clk later, so cpu_wait is high for exactly 1 clk.
- Grant latency with handshake:
  - mcu_halt rises 1 clk after cpu_cs.
  - The grant comes 1 clk after mcu_ba is sampled high.
- Timeout: the forced grant lands TMO+1 clk after entering HREQ.
- Read data reaches the CPU 1 clk after the grant. The CPU samples it at its next cpu_cen, which falls at least 2 clk after the grant at both cen rates.
- Simultaneous events:
  - An MCU write in the same clk that mcu_ba rises is blocked.
  - A CPU write on the grant clk is accepted only if cpu_cen is high that clk.
- Async reset mid-access: a write in flight is dropped, and mcu_halt releases immediately.

## Test plan
- mcu_ban=1; CPU writes 0x5A to 0x1F0, then reads it back → no mcu_halt; cpu_wait high for 1 clk; the read returns 0x5A.
- Handshake: CPU read of 0x010 while mcu_ba rises 6 clk after mcu_halt → cpu_wait high for 8 clk. mcu_halt drops on the first mcu_cen after cpu_cs falls.
- mcu_ba never asserted, TMO=16 → the grant arrives 17 clk after HREQ entry and tmo_err=1. tmo_err stays 1 after a second, normal access.
- MCU writes 0xC3 to 0x100 every mcu_cen while the CPU requests → no MCU write lands once mcu_ba=1. A CPU read of 0x100 returns the last pre-halt value.
- cpu_cs withdrawn in HREQ, and rst pulsed during state CPU → both end in IDLE with no ram_we, mcu_halt=0 and tmo_err=0.
